// File: rtl/regfile_arb_pkg.sv
// regfile_arb_pkg: shared widths, write-back payload type and stage states for the write-back arbiter
package regfile_arb_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;
  typedef enum logic {S_EMPTY, S_FULL} stage_state_e;
endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting at rr_ptr; pointer moves past the winner on advance
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] rr_ptr, win;
  // scan from the farthest offset down so the request nearest rr_ptr overrides
  always_comb begin
    gnt = '0;
    win = '0;
    for (int k = N - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % N]) begin
        gnt = N'(1) << ((int'(rr_ptr) + k) % N);
        win = PW'((int'(rr_ptr) + k) % N);
      end
  end
  // pointer lands just past the winner, wrapping at N-1
  always_ff @(posedge clk or posedge reset)
    if (reset) rr_ptr <= '0;
    else if (advance) rr_ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter with a one-entry stage driving the register file write port; WB_ARB_BUSY_VEC_EN adds busy_vec
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = regfile_arb_pkg::XLEN,
  parameter int REG_ADDR_W = regfile_arb_pkg::REG_ADDR_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          rf_hold,
  output logic                          reg_wr,
  output logic [REG_ADDR_W-1:0]         rd,
  output logic [XLEN-1:0]               wr_data
`ifdef WB_ARB_BUSY_VEC_EN
  ,
  output logic [2**REG_ADDR_W-1:0]      busy_vec
`endif
);
  import regfile_arb_pkg::*;
  stage_state_e state, state_nxt;
  logic [NUM_REQ-1:0] gnt;
  logic can_accept, accept, drain;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0] sel_data;
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(req_valid),
    .advance(accept),
    .gnt(gnt)
  );
  // stage state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= S_EMPTY;
    else state <= state_nxt;
  // accept fills or refills, a lone drain empties, hold keeps the entry
  always_comb state_nxt = accept ? S_FULL : drain ? S_EMPTY : state;
  // grant gating, drain and the x0-filtered write enable
  always_comb begin
    drain = (state == S_FULL) & ~rf_hold;
    can_accept = ~reset & ((state == S_EMPTY) | drain);
    req_ready = gnt & {NUM_REQ{can_accept}};
    accept = |req_ready;
    reg_wr = drain & (rd != '0);
  end
  // payload mux selected by the one-hot grant
  always_comb begin
    sel_rd = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_rd = req_rd[i*REG_ADDR_W +: REG_ADDR_W];
        sel_data = req_data[i*XLEN +: XLEN];
      end
  end
  // stage payload captured on accept; a reset discards it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd <= '0;
      wr_data <= '0;
    end else if (accept) begin
      rd <= sel_rd;
      wr_data <= sel_data;
    end
`ifdef WB_ARB_BUSY_VEC_EN
  // pending non-x0 destination, for RAW stall detection upstream
  always_comb busy_vec = (state == S_FULL && rd != '0) ? (2**REG_ADDR_W)'(1) << rd : '0;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and random checks of the write-back arbiter against a transaction-level model
module tb_regfile_wb_arbiter;
  localparam int N = 3, XL = 32, AW = 5;
  logic clk = 0, reset = 1, rf_hold = 0;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*AW-1:0] req_rd = '0;
  logic [N*XL-1:0] req_data = '0;
  logic reg_wr;
  logic [AW-1:0] rd;
  logic [XL-1:0] wr_data;
`ifdef WB_ARB_BUSY_VEC_EN
  logic [31:0] busy_vec;
`endif
  regfile_wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .REG_ADDR_W(AW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_rd(req_rd),
    .req_data(req_data),
    .req_ready(req_ready),
    .rf_hold(rf_hold),
    .reg_wr(reg_wr),
    .rd(rd),
    .wr_data(wr_data)
`ifdef WB_ARB_BUSY_VEC_EN
    ,
    .busy_vec(busy_vec)
`endif
  );
  always #5 clk = ~clk;
  logic [XL-1:0] tb_rf [32] = '{default: '0};
  always @(posedge clk) if (reg_wr) tb_rf[rd] <= wr_data;
  bit mv [N];
  logic [AW-1:0] mr [N];
  logic [XL-1:0] md [N];
  bit full, hold;
  logic [AW-1:0] srd;
  logic [XL-1:0] sdata;
  int ptr;
  logic [XL-1:0] mrf [32] = '{default: '0};
  int n_chk = 0, n_pass = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic refill(input int pct, input bit x0_ok);
    for (int i = 0; i < N; i++)
      if (!mv[i] && $urandom_range(99) < pct) begin
        mv[i] = 1;
        mr[i] = x0_ok ? AW'($urandom_range(31)) : AW'($urandom_range(31, 1));
        md[i] = $urandom;
      end
  endtask
  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [XL-1:0] d);
    mv[i] = 1;
    mr[i] = r;
    md[i] = d;
  endtask
  task automatic clear_req();
    for (int i = 0; i < N; i++) mv[i] = 0;
  endtask
  task automatic step();
    int win;
    logic [N-1:0] er;
    bit ewr;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = mv[i];
      req_rd[i*AW +: AW] = mr[i];
      req_data[i*XL +: XL] = md[i];
    end
    rf_hold = hold;
    #1;
    win = -1;
    for (int k = 0; k < N; k++) if (win < 0 && mv[(ptr + k) % N]) win = (ptr + k) % N;
    er = '0;
    if (win >= 0 && (!full || !hold)) er[win] = 1'b1;
    ewr = full && !hold && srd != 0;
    check("req_ready", 64'(req_ready), 64'(er));
    check("reg_wr", 64'(reg_wr), 64'(ewr));
    check("rd", 64'(rd), 64'(srd));
    check("wr_data", 64'(wr_data), 64'(sdata));
`ifdef WB_ARB_BUSY_VEC_EN
    check("busy_vec", 64'(busy_vec), (full && srd != 0) ? 64'(1) << srd : 64'(0));
`endif
    @(posedge clk);
    if (ewr) mrf[srd] = sdata;
    if (er != '0) begin
      full = 1;
      srd = mr[win];
      sdata = md[win];
      ptr = (win + 1) % N;
      mv[win] = 0;
    end else if (full && !hold) full = 0;
    @(negedge clk);
  endtask
  initial begin
    clear_req();
    full = 0; hold = 0; srd = '0; sdata = '0; ptr = 0;
    req_valid = '1;
    #3;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_reg_wr", 64'(reg_wr), 64'(0));
    check("rst_rd", 64'(rd), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    reset = 0;
    set_req(0, 5, 32'hDEADBEEF);
    step();
    step();
    step();
    check("x5", 64'(tb_rf[5]), 64'h0000_0000_DEAD_BEEF);
    set_req(2, 4, 32'h0BAD_F00D);
    step();
    step();
    for (int c = 0; c < 6; c++) begin
      refill(100, 0);
      step();
    end
    for (int c = 0; c < 5; c++) step();
    set_req(0, 0, 32'h12345678);
    step();
    set_req(1, 3, 32'hA5A5_0003);
    step();
    step();
    step();
    check("x0", 64'(tb_rf[0]), 64'(0));
    check("x3", 64'(tb_rf[3]), 64'hA5A5_0003);
    set_req(2, 7, 32'h7777_0007);
    step();
    set_req(1, 8, 32'h8888_0008);
    hold = 1;
    for (int c = 0; c < 3; c++) step();
    hold = 0;
    step();
    step();
    step();
    check("x7", 64'(tb_rf[7]), 64'h7777_0007);
    set_req(1, 9, 32'h9999_0009);
    step();
    #2 reset = 1;
    #1;
    check("arst_reg_wr", 64'(reg_wr), 64'(0));
    check("arst_rd", 64'(rd), 64'(0));
    check("arst_wr_data", 64'(wr_data), 64'(0));
    full = 0; srd = '0; sdata = '0; ptr = 0;
    @(negedge clk);
    reset = 0;
    check("x9", 64'(tb_rf[9]), 64'(mrf[9]));
    refill(100, 0);
    step();
    for (int c = 0; c < 400; c++) begin
      refill(60, 1);
      hold = ($urandom_range(3) == 0);
      step();
    end
    hold = 0;
    for (int c = 0; c < 6; c++) step();
    for (int i = 0; i < 32; i++) check("rf", 64'(tb_rf[i]), 64'(mrf[i]));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
